// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: tester-side driver for one scan chain.
// Takes a stimulus pattern through a valid/ready handshake and shifts it into
// the chain with SE high. It then issues one capture cycle, shifts the
// response out of SO, and compares the response against expected data under a
// mask. It reports pass/fail per pattern and keeps a saturating fail count.
//
// Ports:
//   CK, RN       clock (rising edge), asynchronous active-low reset
//   pat_valid    pattern offered
//   pat_ready    controller idle; pattern accepted on valid & ready
//   pat_data     stimulus, bit i lands in chain cell i (cell 0 nearest SO)
//   exp_data     expected captured response, bit i = cell i
//   exp_mask     1 = compare bit, 0 = don't care
//   SE, SI       registered scan enable / scan data into cell CHAIN_LEN-1
//   SO           scan out of the chain (cell 0)
//   res_valid    one-cycle pulse while in REPORT
//   res_fail     masked mismatch of the last reported pattern
//   res_data     last unloaded response, bit i = cell i
//   err_cnt      saturating count of failing patterns
//   clr_err      synchronous clear of err_cnt (wins over an increment)
//   busy         controller not idle
module scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 32,
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned ERR_W     = 16
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic [CHAIN_LEN-1:0] exp_data,
  input  logic [CHAIN_LEN-1:0] exp_mask,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic                 res_valid,
  output logic                 res_fail,
  output logic [CHAIN_LEN-1:0] res_data,
  output logic [ERR_W-1:0]     err_cnt,
  input  logic                 clr_err,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    REPORT  = 3'd4
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  // Stimulus bits still to be presented; bit 0 of the pattern goes straight
  // to SI at accept, so only the upper CHAIN_LEN-1 bits are kept.
  logic [CHAIN_LEN-2:0] pat_sh;
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] mask_q;
  // Response samples collected so far; the final sample comes straight
  // from SO on the last UNLOAD edge.
  logic [CHAIN_LEN-2:0] resp_q;

  logic [CHAIN_LEN-1:0] resp_next_c;
  logic                 fail_next_c;

  // Response including the SO sample taken on the current edge, and its compare.
  always_comb begin
    resp_next_c = {SO, resp_q};
    fail_next_c = |((resp_next_c ^ exp_q) & mask_q);
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state     <= IDLE;
      cnt       <= '0;
      pat_sh    <= '0;
      exp_q     <= '0;
      mask_q    <= '0;
      resp_q    <= '0;
      SE        <= 1'b0;
      SI        <= 1'b0;
      pat_ready <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_fail  <= 1'b0;
      res_data  <= '0;
      err_cnt   <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          SE <= 1'b0;
          SI <= 1'b0;
          if (pat_valid) begin
            state     <= LOAD;
            cnt       <= '0;
            pat_sh    <= pat_data[CHAIN_LEN-1:1];
            exp_q     <= exp_data;
            mask_q    <= exp_mask;
            SE        <= 1'b1;
            SI        <= pat_data[0];
            pat_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (cnt == LAST_CNT) begin
            state <= CAPTURE;
            SE    <= 1'b0;
            SI    <= 1'b0;
          end else begin
            cnt    <= cnt + CNT_W'(1);
            SI     <= pat_sh[0];
            pat_sh <= pat_sh >> 1;
          end
        end
        CAPTURE: begin
          // The chain captured functional data on the edge ending this cycle.
          state <= UNLOAD;
          cnt   <= '0;
          SE    <= 1'b1;
          SI    <= 1'b0;
        end
        UNLOAD: begin
          resp_q <= resp_next_c[CHAIN_LEN-1:1];
          if (cnt == LAST_CNT) begin
            state     <= REPORT;
            SE        <= 1'b0;
            res_valid <= 1'b1;
            res_data  <= resp_next_c;
            res_fail  <= fail_next_c;
            if (fail_next_c && (err_cnt != ERR_MAX)) begin
              err_cnt <= err_cnt + ERR_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REPORT: begin
          state     <= IDLE;
          pat_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          SE        <= 1'b0;
          SI        <= 1'b0;
          pat_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
      // Clear has priority over a coincident failing increment.
      if (clr_err) begin
        err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with a behavioural scan chain whose
// capture inverts every cell, plus a scoreboard of expected results.
module tb_scan_chain_ctrl;
  localparam int unsigned N  = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned EW = 2;

  logic          CK = 1'b0;
  logic          RN = 1'b0;
  logic          pat_valid = 1'b0;
  logic          pat_ready;
  logic [N-1:0]  pat_data = '0;
  logic [N-1:0]  exp_data = '0;
  logic [N-1:0]  exp_mask = '0;
  logic          SE, SI, SO;
  logic          res_valid, res_fail;
  logic [N-1:0]  res_data;
  logic [EW-1:0] err_cnt;
  logic          clr_err = 1'b0;
  logic          busy;

  scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(CW), .ERR_W(EW)) dut (
    .CK(CK), .RN(RN), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_data(pat_data), .exp_data(exp_data), .exp_mask(exp_mask),
    .SE(SE), .SI(SI), .SO(SO), .res_valid(res_valid), .res_fail(res_fail),
    .res_data(res_data), .err_cnt(err_cnt), .clr_err(clr_err), .busy(busy)
  );

  always #5 CK = ~CK;

  // Chain model: shift toward cell 0 when SE=1, capture ~cell when SE=0.
  logic [N-1:0] cells = '0;
  assign SO = cells[0];
  always @(posedge CK) begin
    if (SE) cells <= {SI, cells[N-1:1]};
    else    cells <= ~cells;
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int cyc      = 0;
  always @(posedge CK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    chk_cnt = chk_cnt + 1;
    assert (obs === expv) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  typedef struct {
    logic [N-1:0] data;
    logic         fail;
  } exp_t;

  exp_t sb[$];
  int   acc_cyc[$];
  int   acc_cnt    = 0;
  int   pulse_cnt  = 0;
  logic [EW-1:0] err_model = '0;
  bit   clr_plan   = 1'b0;

  // Push the expected result of each accepted pattern.
  always @(posedge CK) begin : acc_mon
    exp_t e;
    if (RN && pat_valid && pat_ready) begin
      e.data = ~pat_data;
      e.fail = |((~pat_data ^ exp_data) & exp_mask);
      sb.push_back(e);
      acc_cyc.push_back(cyc);
      acc_cnt <= acc_cnt + 1;
    end
  end

  // Pop and compare on every result pulse.
  always @(negedge CK) begin : res_mon
    exp_t e;
    if (res_valid) begin
      pulse_cnt = pulse_cnt + 1;
      chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (clr_plan) err_model = '0;
        else if (e.fail && err_model != 2'd3) err_model = err_model + 2'd1;
        clr_plan = 1'b0;
        chk("res_data", 64'(res_data), 64'(e.data));
        chk("res_fail", 64'(res_fail), 64'(e.fail));
        chk("err_cnt", 64'(err_cnt), 64'(err_model));
      end
    end
  end

  // One pattern with cycle-by-cycle SE/SI, latency and handshake checks.
  task automatic run_pat(input logic [N-1:0] pat, input logic [N-1:0] ex,
                         input logic [N-1:0] mk, input bit scramble, input bit clr_end);
    int a0;
    @(negedge CK);
    pat_data = pat; exp_data = ex; exp_mask = mk; pat_valid = 1'b1;
    a0 = acc_cnt;
    for (int i = 0; i < 40 && acc_cnt == a0; i++) @(negedge CK);
    pat_valid = 1'b0;
    chk("accept", 64'(acc_cnt != a0), 64'(1));
    if (acc_cnt == a0) return;
    for (int j = 0; j < N; j++) begin
      if (j > 0) @(negedge CK);
      chk("load_se", 64'(SE), 64'(1));
      chk("load_si", 64'(SI), 64'(pat[j]));
      if (j == 0) chk("load_ready", 64'({pat_ready, busy}), 64'(2'b01));
      if (scramble && j == 3) begin
        pat_data = N'($urandom);
        exp_data = N'($urandom);
      end
    end
    @(negedge CK);
    chk("capture_se_si", 64'({SE, SI}), 64'(2'b00));
    for (int j = 0; j < N; j++) begin
      @(negedge CK);
      chk("unload_se_si", 64'({SE, SI}), 64'(2'b10));
      if (clr_end && j == N - 1) begin
        clr_err  = 1'b1;
        clr_plan = 1'b1;
      end
    end
    @(negedge CK);
    clr_err = 1'b0;
    chk("report_valid", 64'(res_valid), 64'(1));
    chk("latency", 64'(cyc - acc_cyc[acc_cyc.size()-1]), 64'(2 * N + 2));
    @(negedge CK);
    chk("idle_after", 64'({res_valid, pat_ready, busy}), 64'(3'b010));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    int a0, p0, low;
    int seq[5];
    seq = '{1, 2, 3, 3, 3};

    // Reset values
    repeat (3) @(negedge CK);
    chk("rst_outputs", 64'({SE, SI, res_valid, res_fail, busy}), 64'(0));
    chk("rst_data_err", 64'({res_data, err_cnt}), 64'(0));
    RN = 1'b1;
    @(negedge CK);
    chk("rst_ready", 64'(pat_ready), 64'(1));

    // Basic pass pattern
    run_pat(8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0);
    chk("t1_fail", 64'(res_fail), 64'(0));

    // Failing compare, then the failing bit masked off
    run_pat(8'hA5, 8'h5B, 8'hFF, 1'b0, 1'b0);
    chk("t2_fail", 64'(res_fail), 64'(1));
    chk("t2_err", 64'(err_cnt), 64'(1));
    run_pat(8'hA5, 8'h5B, 8'hFE, 1'b0, 1'b0);
    chk("t2_mask_fail", 64'(res_fail), 64'(0));
    chk("t2_mask_err", 64'(err_cnt), 64'(1));

    // Inputs change mid-LOAD; latched copies must be used
    run_pat(8'h3C, 8'hC3, 8'hFF, 1'b1, 1'b0);
    chk("t6_fail", 64'(res_fail), 64'(0));
    chk("t6_data", 64'(res_data), 64'(8'hC3));

    // Asynchronous reset in the middle of UNLOAD
    @(negedge CK);
    pat_data = 8'h0F; exp_data = 8'h00; exp_mask = 8'hFF; pat_valid = 1'b1;
    a0 = acc_cnt;
    for (int i = 0; i < 40 && acc_cnt == a0; i++) @(negedge CK);
    pat_valid = 1'b0;
    chk("t4_accept", 64'(acc_cnt != a0), 64'(1));
    repeat (N - 1 + 1 + 3) @(negedge CK);
    #2 RN = 1'b0;
    #1;
    chk("t4_async", 64'({SE, SI, busy, res_valid}), 64'(0));
    chk("t4_err", 64'(err_cnt), 64'(0));
    chk("t4_ready", 64'(pat_ready), 64'(1));
    sb.delete();
    err_model = '0;
    p0 = pulse_cnt;
    repeat (2) @(negedge CK);
    RN = 1'b1;
    repeat (25) @(negedge CK);
    #1;
    chk("t4_no_pulse", 64'(pulse_cnt - p0), 64'(0));
    run_pat(8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0);
    chk("t4_recover_data", 64'(res_data), 64'(8'h5A));

    // Back-to-back patterns with pat_valid held high
    @(negedge CK);
    pat_data = 8'h96; exp_data = 8'h69; exp_mask = 8'hFF; pat_valid = 1'b1;
    a0 = acc_cnt;
    p0 = pulse_cnt;
    low = 0;
    for (int i = 0; i < 100 && acc_cnt < a0 + 3; i++) begin
      @(negedge CK);
      if (acc_cnt > a0 && !pat_ready) low++;
    end
    pat_valid = 1'b0;
    chk("t3_accepts", 64'(acc_cnt - a0), 64'(3));
    chk("t3_ready_low", 64'(low), 64'(2 * (2 * N + 2) + 1));
    if (acc_cyc.size() >= 3) begin
      chk("t3_space1", 64'(acc_cyc[acc_cyc.size()-2] - acc_cyc[acc_cyc.size()-3]), 64'(2 * N + 3));
      chk("t3_space2", 64'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 64'(2 * N + 3));
    end
    repeat (2 * N + 4) @(negedge CK);
    #1;
    chk("t3_pulses", 64'(pulse_cnt - p0), 64'(3));

    // Saturation at 3 and clear coinciding with a failing REPORT
    for (int k = 0; k < 5; k++) begin
      run_pat(8'hA5, 8'h00, 8'hFF, 1'b0, 1'b0);
      chk("t5_err_seq", 64'(err_cnt), 64'(seq[k]));
    end
    run_pat(8'hA5, 8'h00, 8'hFF, 1'b0, 1'b1);
    chk("t5_clr_wins", 64'(err_cnt), 64'(0));
    chk("t5_clr_fail", 64'(res_fail), 64'(1));

    repeat (3) @(negedge CK);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
